// File: rtl/instr_mem_sync_if.sv
// Fetch-side interface of the instruction memory: IF-stage request/response pair plus redirect flush.
// The IF stage holds the master end and the memory holds the slave end.
interface instr_mem_sync_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_err;
    logic              flush;

    modport master (
        output req_valid, req_addr, rsp_ready, flush,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, flush,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );
endinterface

// File: rtl/instr_mem_sync.sv
// Run-time loadable instruction memory for the IF stage: 1-cycle valid/ready fetch,
// write-first program port, redirect flush and misaligned/out-of-range flagging.
module instr_mem_sync #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [DATA_W-1:0] FILL_INSTR = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_mem_sync_if.slave       fetch,
    input  logic                  prog_we,
    input  logic [ADDR_W-1:0]     prog_addr,
    input  logic [DATA_W-1:0]     prog_data,
    output logic                  prog_err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             ok;
        logic [IDX_W-1:0] idx;
    } dec_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
    function automatic dec_t decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        dec_t              d;
        off   = addr - BASE_ADDR;
        d.ok  = (addr[1:0] == 2'b00) && (addr >= BASE_ADDR) &&
                ((off >> 2) < ADDR_W'(DEPTH));
        d.idx = off[IDX_W+1:2];
        return d;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;

    state_t            state;
    logic [DATA_W-1:0] rsp_data_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic              rsp_err_q;
    logic              prog_err_q;

    dec_t              prog_dec;
    dec_t              fetch_dec;
    logic              prog_ok;
    logic              accept;
    logic [DATA_W-1:0] fetch_word;

    assign prog_dec  = decode(prog_addr);
    assign fetch_dec = decode(fetch.req_addr);
    assign prog_ok   = prog_we && prog_dec.ok;

    assign fetch.rsp_valid = (state == FULL);
    assign fetch.req_ready = (state == EMPTY) || fetch.rsp_ready;
    assign accept          = fetch.req_valid && fetch.req_ready && !fetch.flush;

    // Write-first: a same-cycle program write to the fetched word bypasses the array.
    always_comb begin
        fetch_word = FILL_INSTR;
        if (fetch_dec.ok) begin
            if (prog_ok && (prog_dec.idx == fetch_dec.idx))
                fetch_word = prog_data;
            else if (written[fetch_dec.idx])
                fetch_word = mem[fetch_dec.idx];
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; the written bits carry validity instead.
    always_ff @(posedge clk) begin
        if (prog_ok && !rst)
            mem[prog_dec.idx] <= prog_data;
    end

    // NOTE: all state below updates with non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            rsp_data_q <= FILL_INSTR;
            rsp_addr_q <= '0;
            rsp_err_q  <= 1'b0;
            prog_err_q <= 1'b0;
            written    <= '0;
        end else begin
            if (prog_ok)
                written[prog_dec.idx] <= 1'b1;
            else if (prog_we)
                prog_err_q <= 1'b1;

            unique case (state)
                EMPTY: begin
                    if (accept)
                        state <= FULL;
                end
                FULL: begin
                    if (fetch.flush)
                        state <= EMPTY;
                    else if (fetch.rsp_ready && !accept)
                        state <= EMPTY;
                end
                default: state <= EMPTY;
            endcase

            if (accept) begin
                rsp_data_q <= fetch_word;
                rsp_addr_q <= fetch.req_addr;
                rsp_err_q  <= !fetch_dec.ok;
            end
        end
    end

    assign fetch.rsp_data = rsp_data_q;
    assign fetch.rsp_addr = rsp_addr_q;
    assign fetch.rsp_err  = rsp_err_q;
    assign prog_err       = prog_err_q;
endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: reset, back-to-back fetch, backpressure, flush,
// error flags, write-first and reset mid-operation, with hand-computed expectations.
module tb_instr_mem_sync;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        prog_err;

    int checks   = 0;
    int failures = 0;

    instr_mem_sync_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    instr_mem_sync dut (
        .clk       (clk),
        .rst       (rst),
        .fetch     (bus.slave),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_err  (prog_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle, so outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic program_word(input logic [31:0] addr, input logic [31:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic fetch_one(input logic [31:0] addr);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] data,
                              input logic [31:0] addr, input logic err);
        check({tag, "_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
        check({tag, "_data"},  bus.rsp_data, data);
        check({tag, "_addr"},  bus.rsp_addr, addr);
        check({tag, "_err"},   {31'b0, bus.rsp_err}, {31'b0, err});
    endtask

    initial begin
        logic [31:0] bb_addr [3];
        logic [31:0] bb_data [3];
        bb_addr = '{32'h4, 32'h8, 32'hc};
        bb_data = '{32'h0000_3f37, 32'h0200_0fe7, NOP};

        rst           = 1'b1;
        prog_we       = 1'b0;
        prog_addr     = '0;
        prog_data     = '0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b1;
        bus.flush     = 1'b0;
        tick();
        tick();

        // Reset state.
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_data",  bus.rsp_data, NOP);
        check("rst_rsp_addr",  bus.rsp_addr, 32'd0);
        check("rst_rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
        check("rst_prog_err",  {31'b0, prog_err}, 32'd0);
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        rst = 1'b0;

        // First fetch of an unwritten word.
        fetch_one(32'h0);
        expect_rsp("first", NOP, 32'h0, 1'b0);
        check("first_prog_err", {31'b0, prog_err}, 32'd0);

        program_word(32'h4,  32'h0000_3f37);
        check("drain_valid", {31'b0, bus.rsp_valid}, 32'd0);
        program_word(32'h8,  32'h0200_0fe7);
        program_word(32'h24, 32'h00c0_006f);

        // Back-to-back fetches, one response per cycle.
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr = bb_addr[i];
            tick();
            expect_rsp($sformatf("b2b%0d", i), bb_data[i], bb_addr[i], 1'b0);
        end
        bus.req_valid = 1'b0;
        tick();
        check("b2b_end_valid", {31'b0, bus.rsp_valid}, 32'd0);

        // Backpressure: response held stable, even while word 0x4 is reprogrammed.
        bus.rsp_ready = 1'b0;
        fetch_one(32'h4);
        for (int i = 0; i < 3; i++) begin
            expect_rsp($sformatf("hold%0d", i), 32'h0000_3f37, 32'h4, 1'b0);
            check($sformatf("hold%0d_req_ready", i), {31'b0, bus.req_ready}, 32'd0);
            if (i == 0) begin
                prog_we   = 1'b1;
                prog_addr = 32'h4;
                prog_data = 32'h1111_1111;
            end
            tick();
            prog_we = 1'b0;
        end
        expect_rsp("hold_end", 32'h0000_3f37, 32'h4, 1'b0);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8;
        #1;
        check("release_req_ready", {31'b0, bus.req_ready}, 32'd1);
        tick();
        expect_rsp("no_bubble", 32'h0200_0fe7, 32'h8, 1'b0);

        // Flush beats a same-cycle request and the handshake.
        bus.req_addr = 32'hc;
        bus.flush    = 1'b1;
        #1;
        check("flush_req_ready", {31'b0, bus.req_ready}, 32'd1);
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        check("flush_valid", {31'b0, bus.rsp_valid}, 32'd0);
        fetch_one(32'h24);
        expect_rsp("redirect", 32'h00c0_006f, 32'h24, 1'b0);

        // Fetch errors and range boundaries.
        fetch_one(32'h6);
        expect_rsp("misalign", NOP, 32'h6, 1'b1);
        fetch_one(32'h100);
        expect_rsp("oor", NOP, 32'h100, 1'b1);
        fetch_one(32'hfc);
        expect_rsp("last_word", NOP, 32'hfc, 1'b0);
        fetch_one(32'h4);
        expect_rsp("reprog_word", 32'h1111_1111, 32'h4, 1'b0);
        check("no_prog_err_yet", {31'b0, prog_err}, 32'd0);

        // Aligned out-of-range program write must not alias onto word 0.
        program_word(32'h100, 32'hdead_beef);
        check("prog_err_oor", {31'b0, prog_err}, 32'd1);
        fetch_one(32'h0);
        expect_rsp("no_alias", NOP, 32'h0, 1'b0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("prog_err_cleared", {31'b0, prog_err}, 32'd0);
        fetch_one(32'h8);
        expect_rsp("written_cleared", NOP, 32'h8, 1'b0);

        program_word(32'h102, 32'h1234_5678);
        check("prog_err_misalign", {31'b0, prog_err}, 32'd1);
        tick();
        tick();
        check("prog_err_sticky", {31'b0, prog_err}, 32'd1);

        // Write-first, plus a same-cycle write to a different word.
        prog_we       = 1'b1;
        prog_addr     = 32'h10;
        prog_data     = 32'h0043_2e83;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h10;
        tick();
        prog_addr     = 32'h14;
        prog_data     = 32'h0000_0533;
        expect_rsp("write_first", 32'h0043_2e83, 32'h10, 1'b0);
        bus.req_addr  = 32'h18;
        tick();
        prog_we       = 1'b0;
        expect_rsp("other_word", NOP, 32'h18, 1'b0);
        bus.req_addr  = 32'h14;
        tick();
        bus.req_valid = 1'b0;
        expect_rsp("other_written", 32'h0000_0533, 32'h14, 1'b0);

        // Reset mid-operation drops the held response and ignores a program write.
        bus.rsp_ready = 1'b0;
        fetch_one(32'h10);
        check("pre_rst_valid", {31'b0, bus.rsp_valid}, 32'd1);
        rst       = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 32'h18;
        prog_data = 32'hcafe_f00d;
        tick();
        rst           = 1'b0;
        prog_we       = 1'b0;
        bus.rsp_ready = 1'b1;
        check("mid_rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("mid_rst_data",  bus.rsp_data, NOP);
        fetch_one(32'h18);
        expect_rsp("rst_write_ignored", NOP, 32'h18, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised, synchronous, loadable instruction memory for the 5-stage RISC-V pipeline IF stage.
- Replaces fixed combinational instruction-table lookup.
- Contents are loaded at run time through a program port; the IF stage fetches through a valid/ready request/response pair with 1-cycle latency.
- Supports flush on branch/jump redirect, and flags misaligned or out-of-range fetches.

Parameters:
- ADDR_W, 32, byte-address width of fetch and program addresses.
- DATA_W, 32, instruction word width.
- DEPTH, 64, number of words; power of two, >=2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; word aligned.
- FILL_INSTR, 32'h0000_0013, word returned for unwritten or erroneous fetches (addi x0,x0,0 NOP).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  ADDR_W  fetch byte address (PC).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_W  fetched instruction.
- rsp_addr  out  ADDR_W  address of the response (PC for the ID stage).
- rsp_err  out  1  the fetch was misaligned or out of range.
- flush  in  1  discard the held response and any same-cycle request.
- prog_we  in  1  program-port write strobe.
- prog_addr  in  ADDR_W  program-port byte address.
- prog_data  in  DATA_W  program-port write data.
- prog_err  out  1  sticky flag: a program write was misaligned or out of range.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: rsp_valid=0, rsp_data=FILL_INSTR, rsp_addr=0, rsp_err=0, prog_err=0. All per-word written bits are cleared. The memory array itself is not reset.
- After reset, every word reads as FILL_INSTR until it is written.
- Index computation: idx = (addr - BASE_ADDR) >> 2, computed in ADDR_W-bit unsigned arithmetic.
  - An address is in range iff addr >= BASE_ADDR and idx < DEPTH.
  - An address is misaligned iff addr[1:0] != 0.
- Program write: when prog_we is high and the address is aligned and in range, mem[idx] and written[idx] are updated on the edge.
  - Otherwise nothing is written and prog_err is set. prog_err stays set until rst.
- req_ready = !rsp_valid || rsp_ready. This is combinational and has no dependence on req_valid.
- Request accepted (req_valid && req_ready && !flush): the next cycle has rsp_valid=1 and rsp_addr=req_addr.
  - If the address is aligned and in range: rsp_err=0, and rsp_data = mem[idx] when written[idx], else FILL_INSTR.
  - Otherwise: rsp_err=1 and rsp_data=FILL_INSTR.
- Same-cycle program write and fetch to the same word: the fetch returns the new prog_data (write-first). Writes to other words do not affect the fetch.
- Hold: while rsp_valid && !rsp_ready, rsp_data/rsp_addr/rsp_err stay stable. This holds even if the same word is reprogrammed meanwhile.
- Response completes on rsp_valid && rsp_ready.
  - If a new request is accepted in the same cycle, rsp_valid stays 1 with the new contents. This gives back-to-back throughput of 1 per cycle.
  - Otherwise rsp_valid goes to 0.
- flush: on the next edge rsp_valid=0. Any request presented that cycle is not accepted, but req_ready still follows the formula above.
  - flush takes priority over rsp_ready and req_valid.
  - The upstream PC must re-present the redirected address on the following cycle.
- Latency: exactly 1 cycle from request acceptance to rsp_valid.
- Only the fetch path has state machine behaviour. The two states are EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY -> FULL on an accepted request.
  - FULL -> EMPTY on a handshake without a new request, or on flush.
  - FULL -> FULL when the response is held, or on a handshake together with a new request.
- Reset mid-operation: a pending response is dropped. A program write in the reset cycle is ignored.
- Address wrap: addr < BASE_ADDR wraps to a large idx and is reported as out of range.

Test Plan:
- Reset: hold rst 2 cycles, then fetch 0x0 -> rsp_valid=1 one cycle later, rsp_data=0x00000013, rsp_err=0, prog_err=0.
- Program 0x4->0x00003f37 and 0x8->0x02000fe7, then fetch 0x4, 0x8, 0xc back-to-back with rsp_ready=1 -> responses on 3 consecutive cycles: 0x00003f37, 0x02000fe7, 0x00000013, with rsp_addr matching each.
- Backpressure: fetch 0x4 with rsp_ready=0 for 3 cycles -> req_ready=0 and rsp_data stable at 0x00003f37. When rsp_ready=1 and a new req at 0x8 arrives, the next rsp is 0x02000fe7 with no bubble.
- Flush: rsp_valid=1 for 0x8, and a req for 0xc is presented with flush=1 -> next cycle rsp_valid=0. A re-presented req at 0x24 then returns its word 1 cycle later.
- Errors: fetch 0x6 -> rsp_err=1, data 0x00000013. Fetch BASE_ADDR+4*DEPTH (0x100 with defaults) -> rsp_err=1. Program write to 0x102 -> prog_err=1, and it remains 1 until rst.
- Write-first: same cycle prog_we to 0x10 with 0x00432e83 and fetch 0x10 -> rsp_data=0x00432e83.
